dac_out_pipe: RTL and testbench

- Pipelined, multi-channel successor to the combinational voltage-to-DAC-code converter.
- Converts signed fixed-point voltages (Q(INT_WIDTH).(FLOAT_WIDTH-INT_WIDTH)) to signed DAC codes by multiplying with a runtime scale.
- Adds round-to-nearest, saturation to DAC range, sticky per-channel saturation flags and a mute control.
- Sits between the SPGD update datapath and the DAC interface; throughput is one sample set per clock.

---
 rtl/dac_out_pipe.sv | 133 +++++++++++++
 tb/tb_dac_out_pipe.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_out_pipe.sv
// Pipelined multi-channel voltage-to-DAC-code converter: fixed-point multiply by a runtime scale,
// round-half-up, clamp to the DAC range, sticky saturation flags and mute.
module dac_out_pipe #(
    parameter int unsigned            FLOAT_WIDTH = 64,
    parameter int unsigned            INT_WIDTH   = 16,
    parameter int unsigned            DAC_WIDTH   = 14,
    parameter int unsigned            N_CH        = 2,
    parameter logic [FLOAT_WIDTH-1:0] SCALE_RST   = {16'hFCCC, 48'hCCCC_CCCC_CCCC}
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [N_CH*FLOAT_WIDTH-1:0] in_volt,
    input  logic [FLOAT_WIDTH-1:0]      scale,
    input  logic                        mute,
    input  logic                        sat_clr,
    output logic                        out_valid,
    output logic [N_CH*DAC_WIDTH-1:0]   out_code,
    output logic [N_CH-1:0]             sat_flags
);

    localparam int unsigned FRAC  = FLOAT_WIDTH - INT_WIDTH;
    localparam int unsigned PW    = 2 * FLOAT_WIDTH;
    localparam int unsigned RW    = PW + 1;
    localparam int unsigned SHIFT = 2 * FRAC;

    localparam int CMAX = (1 <<< (DAC_WIDTH - 1)) - 1;
    localparam int CMIN = -(1 <<< (DAC_WIDTH - 1));

    // One extra bit keeps the +0.5 rounding offset from overflowing the product.
    localparam logic signed [RW-1:0] HALF     = RW'(1) <<< (SHIFT - 1);
    localparam logic signed [RW-1:0] CODE_MAX = RW'(CMAX);
    localparam logic signed [RW-1:0] CODE_MIN = RW'(CMIN);

    // Stage 1: input capture.
    logic                        v1_q;
    logic [N_CH*FLOAT_WIDTH-1:0] volt_q;
    logic [FLOAT_WIDTH-1:0]      scale_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            volt_q  <= '0;
            scale_q <= SCALE_RST;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                volt_q  <= in_volt;
                scale_q <= scale;
            end
        end
    end

    // Stage 2: full-width signed products.
    logic                 v2_q;
    logic signed [PW-1:0] prod_d [N_CH];
    logic signed [PW-1:0] prod_q [N_CH];

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            prod_d[k] = $signed(volt_q[k*FLOAT_WIDTH +: FLOAT_WIDTH]) * $signed(scale_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q <= 1'b0;
        end else begin
            v2_q <= v1_q;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < N_CH; k++) begin
            prod_q[k] <= prod_d[k];
        end
    end

    // Stage 3: round, clamp, mute and flag.
    logic signed [RW-1:0]      rnd_sum [N_CH];
    logic signed [RW-1:0]      rnd     [N_CH];
    logic [N_CH*DAC_WIDTH-1:0] code_d;
    logic [N_CH-1:0]           sat_d;
    logic [N_CH-1:0]           flags_d;
    logic                      out_valid_q;
    logic [N_CH*DAC_WIDTH-1:0] out_code_q;
    logic [N_CH-1:0]           flags_q;

    always_comb begin
        code_d = '0;
        sat_d  = '0;
        for (int k = 0; k < N_CH; k++) begin
            rnd_sum[k] = $signed({prod_q[k][PW-1], prod_q[k]}) + HALF;
            rnd[k]     = rnd_sum[k] >>> SHIFT;
            if (rnd[k] > CODE_MAX) begin
                code_d[k*DAC_WIDTH +: DAC_WIDTH] = CODE_MAX[DAC_WIDTH-1:0];
                sat_d[k]                         = 1'b1;
            end else if (rnd[k] < CODE_MIN) begin
                code_d[k*DAC_WIDTH +: DAC_WIDTH] = CODE_MIN[DAC_WIDTH-1:0];
                sat_d[k]                         = 1'b1;
            end else begin
                code_d[k*DAC_WIDTH +: DAC_WIDTH] = rnd[k][DAC_WIDTH-1:0];
            end
        end
    end

    // A new saturation on the clearing edge wins over the clear.
    always_comb begin
        flags_d = sat_clr ? '0 : flags_q;
        if (v2_q) begin
            flags_d = flags_d | sat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
            flags_q     <= '0;
        end else begin
            out_valid_q <= v2_q;
            flags_q     <= flags_d;
            if (v2_q) begin
                out_code_q <= mute ? '0 : code_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_code  = out_code_q;
    assign sat_flags = flags_q;

endmodule

// File: tb/tb_dac_out_pipe.sv
// Scoreboard bench for dac_out_pipe: driver pushes reference results, a negedge monitor
// pops and compares them against out_valid/out_code/sat_flags every cycle.
module tb_dac_out_pipe;

    localparam int unsigned FW  = 64;
    localparam int unsigned IW  = 16;
    localparam int unsigned DW  = 14;
    localparam int unsigned NCH = 2;
    localparam int unsigned F   = FW - IW;

    localparam logic [FW-1:0] SCALE_RST = {16'hFCCC, 48'hCCCC_CCCC_CCCC};
    localparam logic [FW-1:0] ONE       = 64'h0001_0000_0000_0000;
    localparam logic [FW-1:0] M_ONE     = 64'hFFFF_0000_0000_0000;
    localparam logic [FW-1:0] M_TEN     = 64'hFFF6_0000_0000_0000;
    localparam logic [FW-1:0] P_TWELVE  = 64'h000C_0000_0000_0000;
    localparam logic [FW-1:0] TWO       = 64'h0002_0000_0000_0000;

    bit                   clk;
    logic                 rst;
    logic                 in_valid;
    logic [NCH*FW-1:0]    in_volt;
    logic [FW-1:0]        scale;
    logic                 mute;
    logic                 sat_clr;
    logic                 out_valid;
    logic [NCH*DW-1:0]    out_code;
    logic [NCH-1:0]       sat_flags;

    dac_out_pipe #(
        .FLOAT_WIDTH(FW),
        .INT_WIDTH  (IW),
        .DAC_WIDTH  (DW),
        .N_CH       (NCH),
        .SCALE_RST  (SCALE_RST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_volt  (in_volt),
        .scale    (scale),
        .mute     (mute),
        .sat_clr  (sat_clr),
        .out_valid(out_valid),
        .out_code (out_code),
        .sat_flags(sat_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned      issue;
        logic [NCH*DW-1:0] code;
        logic [NCH-1:0]    sat;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc;
    int          n_chk;
    int          n_fail;
    logic        mute_e;
    logic        clr_e;
    logic        rst_e;

    // Edge index plus the control inputs as seen by that edge.
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        mute_e <= mute;
        clr_e  <= sat_clr;
        rst_e  <= rst;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: exact product, floor, bump by one if the dropped fraction is at least 1/2.
    function automatic void ref_conv(input logic [FW-1:0] v, input logic [FW-1:0] s,
                                     output logic [DW-1:0] code, output logic sat);
        logic signed [2*FW-1:0] p;
        logic signed [2*FW-1:0] whole;
        logic signed [2*FW-1:0] hi;
        logic signed [2*FW-1:0] lo;
        longint                 lim;
        p     = $signed(v) * $signed(s);
        whole = p >>> (2 * F);
        if (p[2*F-1]) whole = whole + 1;
        lim = longint'(1) << (DW - 1);
        hi  = lim - 1;
        lo  = -lim;
        sat = 1'b1;
        if (whole > hi) code = hi[DW-1:0];
        else if (whole < lo) code = lo[DW-1:0];
        else begin
            code = whole[DW-1:0];
            sat  = 1'b0;
        end
    endfunction

    task automatic drive(input logic v, input logic [NCH*FW-1:0] volts, input logic [FW-1:0] s,
                         input logic m, input logic clr, input logic r);
        exp_t          e;
        logic [DW-1:0] cd;
        logic          st;
        in_valid = v;
        in_volt  = volts;
        scale    = s;
        mute     = m;
        sat_clr  = clr;
        rst      = r;
        if (v && !r) begin
            for (int k = 0; k < NCH; k++) begin
                ref_conv(volts[k*FW +: FW], s, cd, st);
                e.code[k*DW +: DW] = cd;
                e.sat[k]           = st;
            end
            e.issue = cyc;
            q.push_back(e);
        end
        // Samples whose output edge is at or after this reset edge never emerge.
        if (r) begin
            while (q.size() > 0 && q[q.size()-1].issue + 3 >= cyc + 1) void'(q.pop_back());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic m, input logic clr);
        drive(1'b0, '0, SCALE_RST, m, clr, 1'b0);
    endtask

    function automatic logic [FW-1:0] rand_volt();
        logic [FW-1:0] v;
        int            ip;
        v = {$urandom(), $urandom()};
        if ($urandom_range(0, 15) != 0) begin
            ip         = int'($urandom_range(0, 40)) - 20;
            v[FW-1:F]  = ip[IW-1:0];
        end
        return v;
    endfunction

    function automatic logic [FW-1:0] rand_scale();
        logic [FW-1:0] s;
        int            ip;
        s = {$urandom(), $urandom()};
        case ($urandom_range(0, 3))
            0: s = SCALE_RST;
            1: s = TWO;
            2: begin
                ip        = int'($urandom_range(0, 2200)) - 1100;
                s[FW-1:F] = ip[IW-1:0];
            end
            default: ;
        endcase
        return s;
    endfunction

    // Monitor
    initial begin
        exp_t             e;
        logic             exp_v;
        logic [NCH*DW-1:0] last_m;
        logic [NCH-1:0]    flags_m;
        last_m  = '0;
        flags_m = '0;
        forever begin
            @(negedge clk);
            if (rst_e === 1'b1) begin
                last_m  = '0;
                flags_m = '0;
                exp_v   = 1'b0;
            end else begin
                while (q.size() > 0 && q[0].issue + 3 < cyc) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL missing_output: got none, expected sample of cycle %0d",
                             q[0].issue);
                    void'(q.pop_front());
                end
                exp_v = (q.size() > 0 && q[0].issue + 3 == cyc);
                if (clr_e) flags_m = '0;
                if (exp_v) begin
                    e       = q.pop_front();
                    last_m  = mute_e ? '0 : e.code;
                    flags_m = flags_m | e.sat;
                end
            end
            chk("mon_valid", 64'(out_valid), 64'(exp_v));
            chk("mon_code", 64'(out_code), 64'(last_m));
            chk("mon_flags", 64'(sat_flags), 64'(flags_m));
        end
    end

    int exp_s[8] = '{0, -819, -1638, -2458, 8, 10, 12, 14};

    initial begin
        logic [DW-1:0] t;
        n_chk  = 0;
        n_fail = 0;
        for (int i = 0; i < 3; i++) drive(1'b0, '0, SCALE_RST, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) idle(1'b0, 1'b0);
        chk("idle_valid", 64'(out_valid), 64'd0);
        chk("idle_code", 64'(out_code), 64'd0);
        chk("idle_flags", 64'(sat_flags), 64'd0);

        // Nominal +1.0 / -1.0
        drive(1'b1, {M_ONE, ONE}, SCALE_RST, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        chk("nom_valid", 64'(out_valid), 64'd1);
        chk("nom_code", 64'(out_code), 64'({14'h0333, 14'h3CCD}));
        chk("nom_flags", 64'(sat_flags), 64'd0);

        // Saturation both rails, then clear
        drive(1'b1, {P_TWELVE, M_TEN}, SCALE_RST, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        chk("sat_code", 64'(out_code), 64'({14'h2000, 14'h1FFF}));
        chk("sat_flags", 64'(sat_flags), 64'd3);
        idle(1'b0, 1'b1);
        chk("sat_clr", 64'(sat_flags), 64'd0);

        // Clear on the same edge as a new saturation: ch1 clears, ch0 sticks
        drive(1'b1, {P_TWELVE, 64'd0}, SCALE_RST, 1'b0, 1'b0, 1'b0);
        drive(1'b1, {64'd0, M_TEN}, SCALE_RST, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b1);
        chk("race_flags", 64'(sat_flags), 64'd1);
        chk("race_code", 64'(out_code), 64'({14'h0000, 14'h1FFF}));
        idle(1'b0, 1'b1);

        // Streaming with a scale switch at sample 4
        for (int k = 0; k < 10; k++) begin
            if (k < 8) drive(1'b1, {64'(k) << F, 64'(k) << F}, (k < 4) ? SCALE_RST : TWO,
                             1'b0, 1'b0, 1'b0);
            else idle(1'b0, 1'b0);
            if (k >= 2) begin
                t = DW'(exp_s[k-2]);
                chk("stream_valid", 64'(out_valid), 64'd1);
                chk("stream_code", 64'(out_code[DW-1:0]), 64'(t));
            end
        end
        idle(1'b0, 1'b0);

        // Mute at the output stage
        drive(1'b1, {ONE, ONE}, SCALE_RST, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b1, 1'b0);
        chk("mute_valid", 64'(out_valid), 64'd1);
        chk("mute_code", 64'(out_code), 64'd0);

        // Reset one cycle after the sample: it must never appear
        drive(1'b1, {ONE, ONE}, SCALE_RST, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, SCALE_RST, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            idle(1'b0, 1'b0);
            chk("rst_flush", 64'(out_valid), 64'd0);
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [FW-1:0] v0;
            logic [FW-1:0] v1;
            logic [FW-1:0] s;
            logic          vv;
            logic          m;
            logic          c;
            logic          r;
            v0 = rand_volt();
            v1 = rand_volt();
            s  = rand_scale();
            vv = ($urandom_range(0, 3) != 0);
            m  = ($urandom_range(0, 7) == 0);
            c  = ($urandom_range(0, 9) == 0);
            r  = ($urandom_range(0, 99) == 0);
            drive(vv, {v1, v0}, s, m, c, r);
        end

        for (int i = 0; i < 5; i++) idle(1'b0, 1'b0);
        chk("drain", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
